unpacked_array_serializer: RTL and testbench

- Consumer of interface `I`. It reads the unpacked array `x [7:0]` through a new input modport `C` (`input x`), the read-side counterpart of the existing output modport `P`.
- On a load handshake it snapshots all elements of `p.x` into a shadow register.
- It then streams the elements one bit per beat over a valid/ready serial port and pulses done after the last beat.
- It sits alongside the existing writer of `I`, so a top level can connect a writer and this reader to the same `I` instance.

---
 rtl/unpacked_array_serializer_pkg.sv | 18 +
 rtl/unpacked_array_serializer_if.sv | 13 +
 rtl/unpacked_array_serializer.sv | 94 +++++++++
 tb/tb_unpacked_array_serializer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/unpacked_array_serializer_pkg.sv
// rtl/unpacked_array_serializer_pkg.sv - shared types and helpers for the array serializer
package asvi_ser_pkg;

  localparam int unsigned DEFAULT_N = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  // Maps the beat counter onto the array element sent on that beat.
  function automatic int unsigned idx_of(input int unsigned counter,
                                         input bit          lsb_first,
                                         input int unsigned n);
    return lsb_first ? counter : (n - 1 - counter);
  endfunction

endpackage

// File: rtl/unpacked_array_serializer_if.sv
// rtl/unpacked_array_serializer_if.sv - interface I carrying the unpacked array x
import asvi_ser_pkg::*;

interface I #(
  parameter int unsigned N = DEFAULT_N
);

  logic x [N-1:0];

  modport P (output x);
  modport C (input x);

endinterface

// File: rtl/unpacked_array_serializer.sv
// rtl/unpacked_array_serializer.sv - snapshots I.x on load and streams it one element per beat
module unpacked_array_serializer
  import asvi_ser_pkg::*;
#(
  parameter int unsigned N         = DEFAULT_N,
  parameter bit          LSB_FIRST = 1'b1,
  localparam int unsigned IW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  I.C                   p,
  input  logic          i_load_valid,
  output logic          o_load_ready,
  input  logic          i_flush,
  output logic          o_ser_valid,
  input  logic          i_ser_ready,
  output logic          o_ser_data,
  output logic [IW-1:0] o_index,
  output logic          o_done
);

  if ($size(p.x) != N) begin : g_size_check
    $error("unpacked_array_serializer: N does not match the size of I.x");
  end

  ser_state_t    state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          shadow_q [N-1:0];
  logic          shadow_d [N-1:0];
  logic          done_q, done_d;
  logic [IW-1:0] idx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      for (int k = 0; k < N; k++) begin
        shadow_q[k] <= 1'b0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Flush outranks load, so a load raised alongside a flush is dropped.
        if (i_load_valid && !i_flush) begin
          for (int k = 0; k < N; k++) begin
            shadow_d[k] = p.x[k];
          end
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (i_flush) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (i_ser_ready) begin
          if (cnt_q == IW'(N - 1)) begin
            cnt_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign idx = IW'(idx_of(int'(cnt_q), LSB_FIRST, N));

  // Outputs come only from registered state; idle presents zeros on data/index.
  always_comb begin
    o_load_ready = (state_q == IDLE);
    o_ser_valid  = (state_q == SEND);
    o_index      = (state_q == SEND) ? idx : '0;
    o_ser_data   = (state_q == SEND) ? shadow_q[idx] : 1'b0;
    o_done       = done_q;
  end

endmodule

// File: tb/tb_unpacked_array_serializer.sv
// tb/tb_unpacked_array_serializer.sv - scoreboard bench for both element orderings
module tb_unpacked_array_serializer;

  localparam int N = 8;

  typedef struct {
    int il;
    int dl;
    int im;
    int dm;
    bit last;
  } beat_t;

  logic       clk;
  logic       rst;
  logic       load;
  logic       flush;
  logic       ready;
  logic       lr_l, sv_l, sd_l, dn_l;
  logic       lr_m, sv_m, sd_m, dn_m;
  logic [2:0] ix_l, ix_m;

  int    total;
  int    bad;
  bit    mon_en;
  bit    ready_auto;
  bit    done_pend;
  beat_t exp_q[$];
  beat_t e;

  I #(.N(N)) bus ();

  unpacked_array_serializer #(.N(N), .LSB_FIRST(1'b1)) u_lsb (
    .i_clk        (clk),
    .i_rst        (rst),
    .p            (bus.C),
    .i_load_valid (load),
    .o_load_ready (lr_l),
    .i_flush      (flush),
    .o_ser_valid  (sv_l),
    .i_ser_ready  (ready),
    .o_ser_data   (sd_l),
    .o_index      (ix_l),
    .o_done       (dn_l)
  );

  unpacked_array_serializer #(.N(N), .LSB_FIRST(1'b0)) u_msb (
    .i_clk        (clk),
    .i_rst        (rst),
    .p            (bus.C),
    .i_load_valid (load),
    .o_load_ready (lr_m),
    .i_flush      (flush),
    .o_ser_valid  (sv_m),
    .i_ser_ready  (ready),
    .o_ser_data   (sd_m),
    .o_index      (ix_m),
    .o_done       (dn_m)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: the DUT should be busy exactly while the scoreboard holds beats.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("valid_lsb", int'(sv_l), int'(exp_q.size() != 0));
      chk("valid_msb", int'(sv_m), int'(exp_q.size() != 0));
      chk("load_ready_lsb", int'(lr_l), int'(exp_q.size() == 0));
      chk("load_ready_msb", int'(lr_m), int'(exp_q.size() == 0));
      chk("done_lsb", int'(dn_l), int'(done_pend));
      chk("done_msb", int'(dn_m), int'(done_pend));
      done_pend = 1'b0;
      if (exp_q.size() != 0 && sv_l) begin
        e = exp_q[0];
        chk("index_lsb", int'(ix_l), e.il);
        chk("data_lsb", int'(sd_l), e.dl);
        chk("index_msb", int'(ix_m), e.im);
        chk("data_msb", int'(sd_m), e.dm);
        if (ready && !flush && !rst) begin
          void'(exp_q.pop_front());
          done_pend = e.last;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_auto) ready = ($urandom % 4) != 0;
    end
  end

  task automatic set_x(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) bus.x[k] = v[k];
  endtask

  task automatic push_xfer(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      beat_t b;
      b.il   = k;
      b.dl   = int'(v[k]);
      b.im   = N - 1 - k;
      b.dm   = int'(v[N-1-k]);
      b.last = (k == N - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_size(input int n);
    int c;
    c = 0;
    while (exp_q.size() > n && c < 400) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (exp_q.size() > n) begin
      total++;
      bad++;
      $display("FAIL drain_timeout actual=%0d expected<=%0d", exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  task automatic do_load(input logic [N-1:0] v);
    wait_size(0);
    set_x(v);
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    push_xfer(v);
  endtask

  task automatic chk_reset_values();
    @(negedge clk);
    chk("rst_index_lsb", int'(ix_l), 0);
    chk("rst_index_msb", int'(ix_m), 0);
    chk("rst_data_lsb", int'(sd_l), 0);
    chk("rst_data_msb", int'(sd_m), 0);
    chk("rst_valid", int'(sv_l | sv_m), 0);
    chk("rst_load_ready", int'(lr_l & lr_m), 1);
    chk("rst_done", int'(dn_l | dn_m), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic abort_with(input bit use_rst);
    if (use_rst) rst = 1'b1;
    else flush = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    flush = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    logic [N-1:0] v;
    total      = 0;
    bad        = 0;
    mon_en     = 1'b0;
    ready_auto = 1'b0;
    done_pend  = 1'b0;
    rst        = 1'b1;
    load       = 1'b0;
    flush      = 1'b0;
    ready      = 1'b1;
    set_x('0);
    @(posedge clk);
    #1;
    chk_reset_values();
    rst    = 1'b0;
    mon_en = 1'b1;

    // Directed pattern, both orderings, ready held high.
    do_load(8'b1011_0010);
    wait_size(0);

    // Backpressure for three cycles after the first beat.
    do_load(8'b1011_0010);
    @(posedge clk);
    #1;
    ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    ready = 1'b1;

    // Snapshot: source changes and a mid-transfer load must not disturb it.
    do_load(8'hFF);
    set_x('0);
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    wait_size(0);

    // Flush after three accepts, then restart with fresh data.
    ready_auto = 1'b1;
    do_load(8'h5A);
    wait_size(5);
    abort_with(1'b0);
    do_load(8'hC3);

    // Synchronous reset after five beats.
    do_load(8'h96);
    wait_size(3);
    abort_with(1'b1);
    chk_reset_values();

    // Reset and load together: no capture.
    set_x('1);
    rst  = 1'b1;
    load = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    load = 1'b0;
    chk_reset_values();

    // Flush and load together in idle: no capture.
    flush = 1'b1;
    load  = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    load  = 1'b0;
    @(posedge clk);
    #1;

    // Flush coinciding with the final accept suppresses done.
    ready_auto = 1'b0;
    ready      = 1'b1;
    do_load(8'h3C);
    wait_size(1);
    abort_with(1'b0);
    @(posedge clk);
    #1;

    // Randomized transfers with occasional flushes.
    ready_auto = 1'b1;
    for (int t = 0; t < 40; t++) begin
      v = N'($urandom);
      do_load(v);
      if (($urandom % 4) == 0) begin
        wait_size(int'($urandom_range(1, N - 1)));
        abort_with(1'b0);
      end
    end
    wait_size(0);
    ready_auto = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
